// File: rtl/mips_pkg.sv
// Types and constants shared between the fetch stage and the control unit.
// The opcode values are the MIPS primary opcode field, bits [31:26].
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } if_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;

  // One-entry skid buffer: a word that came back while decode was stalled.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } skid_t;

  localparam skid_t SKID_EMPTY = '{valid: 1'b0, instr: NOP};

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response channel: req/gnt handshake for the
// address, rvalid strobe for the returned word.
interface instruction_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: single-outstanding imem requests, IF/ID
// register with a one-entry skid buffer for stalls, branch redirect/flush.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_if.master        imem,
  input  logic                       stall,
  input  logic                       branch_taken,
  input  logic [31:0]                branch_target,
  output logic                       if_id_valid,
  output logic [31:0]                if_id_instr,
  output logic [31:0]                if_id_pc4,
  output logic [5:0]                 opcode
);

  if_state_e   state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_pc, req_pc_n;
  skid_t       skid, skid_n;
  logic        valid_n;
  logic [31:0] instr_n, pc4_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      skid        <= SKID_EMPTY;
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      if_id_pc4   <= 32'h0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      req_pc      <= req_pc_n;
      skid        <= skid_n;
      if_id_valid <= valid_n;
      if_id_instr <= instr_n;
      if_id_pc4   <= pc4_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    req_pc_n = req_pc;
    skid_n   = skid;
    valid_n  = if_id_valid;
    instr_n  = if_id_instr;
    pc4_n    = if_id_pc4;

    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (imem.gnt) begin
          req_pc_n = pc;
          pc_n     = pc + 32'd4;
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (imem.rvalid) begin
          if (!stall) begin
            valid_n = 1'b1;
            instr_n = imem.rdata;
            pc4_n   = req_pc + 32'd4;
            state_n = FETCH;
          end else begin
            skid_n  = '{valid: 1'b1, instr: imem.rdata};
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        // req_pc is untouched while holding, so pc4 is rebuilt from it.
        if (!stall) begin
          valid_n = skid.valid;
          instr_n = skid.instr;
          pc4_n   = req_pc + 32'd4;
          skid_n  = SKID_EMPTY;
          state_n = FETCH;
        end
      end
      DISCARD: begin
        if (imem.rvalid) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase

    // A redirect overrides everything above; a request already granted must
    // still be drained, which is what DISCARD is for.
    if (branch_taken) begin
      pc_n    = word_align(branch_target);
      valid_n = 1'b0;
      instr_n = NOP;
      pc4_n   = 32'h0;
      skid_n  = SKID_EMPTY;
      unique case (state)
        FETCH:   state_n = imem.gnt    ? DISCARD : FETCH;
        WAIT:    state_n = imem.rvalid ? FETCH   : DISCARD;
        DISCARD: state_n = DISCARD;
        default: state_n = FETCH;
      endcase
    end
  end

  assign imem.req  = (state == FETCH);
  assign imem.addr = pc;
  assign opcode    = if_id_instr[31:26];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven check of instruction_fetch with RESET_PC = 0x100,
// plus a hand-written reset-while-holding sequence.
module tb_instruction_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc4;
  logic [5:0]  opcode;

  instruction_fetch_if imem ();

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem.master),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .opcode        (opcode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        stall, br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr, pc4;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic add(input logic gnt, rv, input logic [31:0] rdata,
                     input logic st, br, input logic [31:0] tgt,
                     input logic req, input logic [31:0] addr,
                     input logic valid, input logic [31:0] instr, pc4);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.stall = st; v.br = br; v.tgt = tgt;
    v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.pc4 = pc4;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req"},   {31'h0, imem.req}, 32'h0);
    chk({tag, " addr"},  imem.addr, 32'h100);
    chk({tag, " valid"}, {31'h0, if_id_valid}, 32'h0);
    chk({tag, " instr"}, if_id_instr, 32'h0);
    chk({tag, " pc4"},   if_id_pc4, 32'h0);
    chk({tag, " opcode"}, {26'h0, opcode}, 32'h0);
  endtask

  task automatic drive(input logic g, rv, input logic [31:0] rd, input logic st, br,
                       input logic [31:0] tgt);
    imem.gnt = g; imem.rvalid = rv; imem.rdata = rd;
    stall = st; branch_taken = br; branch_target = tgt;
  endtask

  initial begin
    logic [31:0] exp_instr;
    bit seen;

    //   gnt rv rdata         st br tgt            | req addr          v instr         pc4
    add(0, 0, 32'h0,        0, 0, 32'h0,          0, 32'h100,       0, 32'h0,        32'h0);   // IDLE
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h100,       0, 32'h0,        32'h0);
    add(0, 1, 32'h8C010004, 0, 0, 32'h0,          0, 32'h104,       0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h104,       1, 32'h8C010004, 32'h104);
    add(0, 1, 32'h00221820, 0, 0, 32'h0,          0, 32'h108,       1, 32'h8C010004, 32'h104);
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h108,       1, 32'h00221820, 32'h108);
    add(0, 1, 32'hAC030008, 0, 0, 32'h0,          0, 32'h10C,       1, 32'h00221820, 32'h108);
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h10C,       1, 32'hAC030008, 32'h10C);
    // stall covering an rvalid, held three cycles
    add(0, 1, 32'h10220003, 1, 0, 32'h0,          0, 32'h110,       1, 32'hAC030008, 32'h10C);
    add(0, 0, 32'h0,        1, 0, 32'h0,          0, 32'h110,       1, 32'hAC030008, 32'h10C);
    add(0, 0, 32'h0,        1, 0, 32'h0,          0, 32'h110,       1, 32'hAC030008, 32'h10C);
    add(0, 0, 32'h0,        0, 0, 32'h0,          0, 32'h110,       1, 32'hAC030008, 32'h10C);
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h110,       1, 32'h10220003, 32'h110);
    // redirect while waiting; low target bits dropped
    add(0, 0, 32'h0,        0, 1, 32'h203,        0, 32'h114,       1, 32'h10220003, 32'h110);
    add(0, 0, 32'h0,        0, 0, 32'h0,          0, 32'h200,       0, 32'h0,        32'h0);
    add(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,          0, 32'h200,       0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h200,       0, 32'h0,        32'h0);
    add(0, 1, 32'h8C050010, 0, 0, 32'h0,          0, 32'h204,       0, 32'h0,        32'h0);
    // request held without grant, then redirect + stall together
    add(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h204,       1, 32'h8C050010, 32'h204);
    add(0, 0, 32'h0,        1, 1, 32'h300,        1, 32'h204,       1, 32'h8C050010, 32'h204);
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h300,       0, 32'h0,        32'h0);
    // redirect coincident with rvalid, into the top of the address space
    add(0, 1, 32'h12345678, 0, 1, 32'hFFFFFFFC,   0, 32'h304,       0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'hFFFFFFFC,  0, 32'h0,        32'h0);
    add(0, 1, 32'h00000020, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h0,         1, 32'h00000020, 32'h0);
    add(0, 1, 32'h8C000000, 0, 0, 32'h0,          0, 32'h4,         1, 32'h00000020, 32'h0);
    // redirect in the same cycle as a grant: drain then fetch target
    add(1, 0, 32'h0,        0, 1, 32'h400,        1, 32'h4,         1, 32'h8C000000, 32'h4);
    add(0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,          0, 32'h400,       0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        0, 0, 32'h0,          1, 32'h400,       0, 32'h0,        32'h0);
    // redirect while holding a skid word
    add(0, 1, 32'h11111111, 1, 0, 32'h0,          0, 32'h404,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 1, 32'h500,        0, 32'h404,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h500,       0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 0, 32'h0,          1, 32'h500,       0, 32'h0,        32'h0);

    drive(0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      exp_instr = vecs[i].instr;
      chk($sformatf("v%0d req", i),    {31'h0, imem.req}, {31'h0, vecs[i].req});
      chk($sformatf("v%0d addr", i),   imem.addr, vecs[i].addr);
      chk($sformatf("v%0d valid", i),  {31'h0, if_id_valid}, {31'h0, vecs[i].valid});
      chk($sformatf("v%0d instr", i),  if_id_instr, exp_instr);
      chk($sformatf("v%0d pc4", i),    if_id_pc4, vecs[i].pc4);
      chk($sformatf("v%0d opcode", i), {26'h0, opcode}, {26'h0, exp_instr[31:26]});
      drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].stall, vecs[i].br, vecs[i].tgt);
      @(negedge clk);
    end

    // Reset asserted while in HOLD with a valid IF/ID entry.
    drive(1, 0, 32'h0, 0, 0, 32'h0);          @(negedge clk);  // FETCH 0x500 -> WAIT
    drive(0, 1, 32'h8C0A0000, 0, 0, 32'h0);   @(negedge clk);  // load IF/ID
    drive(1, 0, 32'h0, 0, 0, 32'h0);          @(negedge clk);  // FETCH 0x504 -> WAIT
    drive(0, 1, 32'hAC000000, 1, 0, 32'h0);   @(negedge clk);  // into HOLD
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    chk("hold req",    {31'h0, imem.req}, 32'h0);
    chk("hold valid",  {31'h0, if_id_valid}, 32'h1);
    chk("hold instr",  if_id_instr, 32'h8C0A0000);
    chk("hold pc4",    if_id_pc4, 32'h504);
    chk("hold opcode", {26'h0, opcode}, {26'h0, OP_LW});
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async rst");
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("post-rst idle req", {31'h0, imem.req}, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (imem.req) seen = 1'b1;
    end
    chk("post-rst req seen", {31'h0, seen}, 32'h1);
    chk("post-rst addr", imem.addr, 32'h100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
